uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the single UART transmitter between NUM_REQ byte producers (register file readback, ALU result path, etc.). It accepts one byte per requester via a valid/ready handshake and drives the transmitter's parallel data, one-cycle Data_Valid pulse and busy feedback. It guarantees one byte in flight at a time and reports a lost handshake, i.e. the transmitter never asserting busy.

---
 rtl/uart_tx_arbiter_if.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side handshake bundle for the UART TX arbiter.
// The master modport is the arbiter; the slave modport is the environment (requesters + transmitter).
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         TX_P_DATA;
  logic                          TX_DATA_VALID;
  logic                          TX_BUSY;

  modport master (
    input  req_valid, req_data, TX_BUSY,
    output req_ready, TX_P_DATA, TX_DATA_VALID
  );

  modport slave (
    output req_valid, req_data, TX_BUSY,
    input  req_ready, TX_P_DATA, TX_DATA_VALID
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte producers.
// One byte in flight at a time; a launch the transmitter never acknowledges raises a sticky tx_err.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 4,
  localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  uart_tx_arbiter_if.master      bus,
  output logic [GW-1:0]          grant_id,
  output logic                   arb_busy,
  output logic                   tx_err,
  input  logic                   err_clr
);

  localparam int CW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                state_q;
  logic [NUM_REQ-1:0]    req_ready_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_dv_q;
  logic [GW-1:0]         grant_q;
  logic [GW-1:0]         rr_q;
  logic [CW-1:0]         cnt_q;
  logic                  tx_err_q;
  logic                  arb_busy_q;

  logic [GW-1:0]         win_d;
  logic [NUM_REQ-1:0]    win_onehot_d;
  logic                  any_valid_d;

  // First requesting index strictly after the last winner, wrapping around.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [GW-1:0]      last);
    logic [GW-1:0] w;
    logic          found;
    int            idx;
    w     = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && v[idx]) begin
        w     = GW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_comb begin
    any_valid_d  = |bus.req_valid;
    win_d        = rr_pick(bus.req_valid, rr_q);
    win_onehot_d = NUM_REQ'(1) << win_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      req_ready_q <= '0;
      tx_data_q   <= '0;
      tx_dv_q     <= 1'b0;
      grant_q     <= '0;
      rr_q        <= GW'(NUM_REQ - 1);
      cnt_q       <= '0;
      tx_err_q    <= 1'b0;
      arb_busy_q  <= 1'b0;
    end else begin
      req_ready_q <= '0;
      tx_dv_q     <= 1'b0;
      if (err_clr) tx_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A busy transmitter here is a frame still draining after a timeout.
          if (any_valid_d && !bus.TX_BUSY) begin
            state_q     <= LAUNCH;
            arb_busy_q  <= 1'b1;
            tx_dv_q     <= 1'b1;
            req_ready_q <= win_onehot_d;
            tx_data_q   <= bus.req_data[win_d*DATA_WIDTH +: DATA_WIDTH];
            grant_q     <= win_d;
            rr_q        <= win_d;
          end
        end
        LAUNCH: begin
          state_q <= WAIT_BUSY;
          cnt_q   <= '0;
        end
        WAIT_BUSY: begin
          if (bus.TX_BUSY) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
            tx_err_q   <= 1'b1;
            state_q    <= IDLE;
            arb_busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (!bus.TX_BUSY) begin
            state_q    <= IDLE;
            arb_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          arb_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.TX_P_DATA     = tx_data_q;
  assign bus.TX_DATA_VALID = tx_dv_q;
  assign grant_id          = grant_q;
  assign arb_busy          = arb_busy_q;
  assign tx_err            = tx_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART transmitter model.
module tb_uart_tx_arbiter;
  localparam int NR       = 2;
  localparam int DW       = 8;
  localparam int BT       = 4;
  localparam int BUSY_LEN = 11;

  logic       CLK = 1'b0;
  logic       RST;
  logic       err_clr;
  logic [0:0] grant_id;
  logic       arb_busy;
  logic       tx_err;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .grant_id (grant_id),
    .arb_busy (arb_busy),
    .tx_err   (tx_err),
    .err_clr  (err_clr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [0:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   model_en = 1'b1;

  // Transmitter model: busy for BUSY_LEN cycles starting the cycle after a launch.
  initial begin
    int  busy_left;
    bit  start_next;
    busy_left   = 0;
    start_next  = 1'b0;
    bus.TX_BUSY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) bus.TX_BUSY = 1'b0;
      end
      if (start_next) begin
        bus.TX_BUSY = 1'b1;
        busy_left   = BUSY_LEN;
        start_next  = 1'b0;
      end
      if (bus.TX_DATA_VALID === 1'b1 && model_en) start_next = 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_launch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.TX_DATA_VALID === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (arb_busy === 1'b0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    bit   ok;
    exp_t e;
    RST           = 1'b1;
    err_clr       = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_data  = 16'h4433;
    repeat (3) tick();
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b required 00", bus.req_ready); end
    checks++; if (bus.TX_P_DATA !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h required 00", bus.TX_P_DATA); end
    checks++; if (bus.TX_DATA_VALID !== 1'b0) begin errors++; $display("FAIL rst_tx_dv: got %b required 0", bus.TX_DATA_VALID); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL rst_grant: got %0d required 0", grant_id); end
    checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL rst_tx_err: got %b required 0", tx_err); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL rst_arb_busy: got %b required 0", arb_busy); end
    sb.push_back('{id: 1'b0, data: 8'h33});
    RST = 1'b0;
    wait_launch(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_first_launch: got no launch required launch"); end
    else begin
      e = sb.pop_front();
      bus.req_valid = 2'b00;
      checks++; if (grant_id !== e.id) begin errors++; $display("FAIL rst_first_grant: got %0d required %0d", grant_id, e.id); end
      checks++; if (bus.TX_P_DATA !== e.data) begin errors++; $display("FAIL rst_first_data: got %h required %h", bus.TX_P_DATA, e.data); end
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rst_first_ready: got %b required 01", bus.req_ready); end
    end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_idle: got busy required idle"); end
  endtask

  task automatic test_single;
    bit   ok;
    int   n;
    exp_t e;
    bus.req_valid = 2'b10;
    bus.req_data  = 16'hA500;
    sb.push_back('{id: 1'b1, data: 8'hA5});
    wait_launch(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_launch: got no launch required launch"); return; end
    bus.req_valid = 2'b00;
    e = sb.pop_front();
    checks++; if (bus.TX_P_DATA !== e.data) begin errors++; $display("FAIL single_data: got %h required %h", bus.TX_P_DATA, e.data); end
    checks++; if (grant_id !== e.id) begin errors++; $display("FAIL single_grant: got %0d required %0d", grant_id, e.id); end
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL single_ready: got %b required 10", bus.req_ready); end
    tick();
    checks++; if (bus.TX_DATA_VALID !== 1'b0) begin errors++; $display("FAIL single_dv_pulse: got %b required 0", bus.TX_DATA_VALID); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL single_ready_pulse: got %b required 00", bus.req_ready); end
    n = 1;
    while (arb_busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n !== BUSY_LEN + 2) begin errors++; $display("FAIL single_busy_len: got %0d required %0d", n, BUSY_LEN + 2); end
    checks++; if (bus.TX_P_DATA !== 8'hA5) begin errors++; $display("FAIL single_data_hold: got %h required a5", bus.TX_P_DATA); end
  endtask

  task automatic test_round_robin;
    bit   got;
    exp_t e;
    bus.req_valid = 2'b11;
    bus.req_data  = 16'h2211;
    for (int k = 0; k < 4; k++)
      sb.push_back('{id: k[0], data: (k[0] ? 8'h22 : 8'h11)});
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        tick();
        checks++;
        if (bus.TX_DATA_VALID === 1'b1 && bus.TX_BUSY === 1'b1) begin
          errors++; $display("FAIL rr_overlap: got launch while busy required none");
        end
        if (bus.TX_DATA_VALID === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got) begin errors++; $display("FAIL rr_launch%0d: got no launch required launch", k); end
      else begin
        e = sb.pop_front();
        if (k == 3) bus.req_valid = 2'b00;
        checks++; if (bus.TX_P_DATA !== e.data) begin errors++; $display("FAIL rr_data%0d: got %h required %h", k, bus.TX_P_DATA, e.data); end
        checks++; if (grant_id !== e.id) begin errors++; $display("FAIL rr_grant%0d: got %0d required %0d", k, grant_id, e.id); end
        checks++; if (bus.req_ready !== (2'b01 << e.id)) begin errors++; $display("FAIL rr_ready%0d: got %b required %b", k, bus.req_ready, 2'b01 << e.id); end
      end
    end
    bus.req_valid = 2'b00;
    wait_idle(got);
    checks++; if (!got) begin errors++; $display("FAIL rr_idle: got busy required idle"); end
  endtask

  task automatic test_timeout;
    bit   ok;
    exp_t e;
    model_en      = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_data  = 16'h005A;
    sb.push_back('{id: 1'b0, data: 8'h5A});
    wait_launch(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_launch: got no launch required launch"); return; end
    bus.req_valid = 2'b00;
    e = sb.pop_front();
    checks++; if (bus.TX_P_DATA !== e.data) begin errors++; $display("FAIL to_data: got %h required %h", bus.TX_P_DATA, e.data); end
    repeat (BT) tick();
    checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL to_err_early: got %b required 0", tx_err); end
    checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL to_busy_wait: got %b required 1", arb_busy); end
    tick();
    checks++; if (tx_err !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b required 1", tx_err); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL to_idle: got %b required 0", arb_busy); end
    model_en      = 1'b1;
    bus.req_valid = 2'b10;
    bus.req_data  = 16'h7700;
    sb.push_back('{id: 1'b1, data: 8'h77});
    wait_launch(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_next_launch: got no launch required launch"); return; end
    bus.req_valid = 2'b00;
    e = sb.pop_front();
    checks++; if (bus.TX_P_DATA !== e.data) begin errors++; $display("FAIL to_next_data: got %h required %h", bus.TX_P_DATA, e.data); end
    checks++; if (grant_id !== e.id) begin errors++; $display("FAIL to_next_grant: got %0d required %0d", grant_id, e.id); end
    checks++; if (tx_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b required 1", tx_err); end
    wait_idle(ok);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b required 0", tx_err); end
    model_en      = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_data  = 16'h0099;
    sb.push_back('{id: 1'b0, data: 8'h99});
    wait_launch(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to2_launch: got no launch required launch"); return; end
    bus.req_valid = 2'b00;
    e = sb.pop_front();
    checks++; if (bus.TX_P_DATA !== e.data) begin errors++; $display("FAIL to2_data: got %h required %h", bus.TX_P_DATA, e.data); end
    repeat (BT) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (tx_err !== 1'b1) begin errors++; $display("FAIL to2_set_wins: got %b required 1", tx_err); end
    tick();
    checks++; if (tx_err !== 1'b1) begin errors++; $display("FAIL to2_sticky: got %b required 1", tx_err); end
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid;
    bit   ok;
    int   fall_c;
    int   launch_c;
    exp_t e;
    bus.req_valid = 2'b10;
    bus.req_data  = 16'hC300;
    sb.push_back('{id: 1'b1, data: 8'hC3});
    wait_launch(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rm_launch: got no launch required launch"); return; end
    bus.req_valid = 2'b00;
    e = sb.pop_front();
    checks++; if (bus.TX_P_DATA !== e.data) begin errors++; $display("FAIL rm_data: got %h required %h", bus.TX_P_DATA, e.data); end
    repeat (3) tick();
    RST           = 1'b1;
    bus.req_valid = 2'b01;
    bus.req_data  = 16'h00D4;
    tick();
    RST = 1'b0;
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL rm_arb_busy: got %b required 0", arb_busy); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rm_ready: got %b required 00", bus.req_ready); end
    checks++; if (bus.TX_BUSY !== 1'b1) begin errors++; $display("FAIL rm_tx_still_busy: got %b required 1", bus.TX_BUSY); end
    sb.push_back('{id: 1'b0, data: 8'hD4});
    fall_c   = -1;
    launch_c = -1;
    for (int c = 0; c < 40 && launch_c < 0; c++) begin
      tick();
      if (bus.TX_BUSY === 1'b0 && fall_c < 0) fall_c = c;
      if (bus.TX_DATA_VALID === 1'b1) launch_c = c;
    end
    checks++;
    if (launch_c < 0 || fall_c < 0) begin errors++; $display("FAIL rm_relaunch: got no launch required launch"); return; end
    checks++; if (launch_c !== fall_c + 1) begin errors++; $display("FAIL rm_launch_after_busy: got cycle %0d required %0d", launch_c, fall_c + 1); end
    bus.req_valid = 2'b00;
    e = sb.pop_front();
    checks++; if (bus.TX_P_DATA !== e.data) begin errors++; $display("FAIL rm_relaunch_data: got %h required %h", bus.TX_P_DATA, e.data); end
    checks++; if (grant_id !== e.id) begin errors++; $display("FAIL rm_relaunch_grant: got %0d required %0d", grant_id, e.id); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_idle: got busy required idle"); end
  endtask

  task automatic test_withdrawn;
    bit   ok;
    int   bad;
    exp_t e;
    bus.req_valid = 2'b10;
    bus.req_data  = 16'h3C00;
    sb.push_back('{id: 1'b1, data: 8'h3C});
    wait_launch(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wd_launch: got no launch required launch"); return; end
    bus.req_valid = 2'b00;
    e = sb.pop_front();
    checks++; if (bus.TX_P_DATA !== e.data) begin errors++; $display("FAIL wd_data: got %h required %h", bus.TX_P_DATA, e.data); end
    repeat (2) tick();
    bus.req_valid = 2'b01;
    bus.req_data  = 16'h3CEE;
    bad = 0;
    repeat (3) begin
      tick();
      if (bus.TX_DATA_VALID !== 1'b0 || bus.req_ready !== 2'b00) bad++;
    end
    bus.req_valid = 2'b00;
    for (int c = 0; c < 40 && arb_busy === 1'b1; c++) begin
      tick();
      if (bus.TX_DATA_VALID !== 1'b0 || bus.req_ready !== 2'b00) bad++;
    end
    repeat (4) begin
      tick();
      if (bus.TX_DATA_VALID !== 1'b0 || bus.req_ready !== 2'b00) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL wd_no_launch: got %0d launch cycles required 0", bad); end
    checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL wd_grant: got %0d required 1", grant_id); end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL wd_sb_empty: got %0d pending required 0", sb.size()); end
  endtask

  initial begin
    RST           = 1'b1;
    err_clr       = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_withdrawn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
